// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t      : interlock FSM encoding (RUN=00, LOAD_STALL=01, FLUSH=10)
//   FWD_*           : EX operand source selects driven on id_fwd_rs1/id_fwd_rs2
//   shadow_entry_t  : destination-register info tracked for EX, MEM and WB
package riscv_core_pkg;

  localparam int RF_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] rd;
    logic                wr;
    logic                load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '0;

endpackage

// File: rtl/riscv_core_hazard_match.sv
// Source-register versus shadow-entry comparator.
//   entry_valid/entry_wr/entry_rd : one shadow pipeline entry
//   rs, rs_used                   : one source operand of the instruction in ID
//   hit                           : the entry will write the register ID reads
// x0 is hard-wired zero, so an entry targeting it never matches.
module riscv_core_hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic              entry_valid,
  input  logic              entry_wr,
  input  logic [REG_AW-1:0] entry_rd,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  output logic              hit
);

  assign hit = entry_valid & entry_wr & rs_used
             & (entry_rd != '0) & (entry_rd == rs);

endmodule

// File: rtl/riscv_core_hazard.sv
// Interlock and forwarding controller for the 5-stage core (IF ID EX MEM WB).
// Keeps a shadow copy of {valid, rd, wr, load} for EX, MEM and WB and derives:
//   id_fwd_rs1/2 : EX operand source (00 RF, 01 EX, 10 MEM, 11 WB)
//   id_stall     : hold PC and IF/ID
//   id_bubble    : inject a NOP into EX
//   if_flush     : discard the instructions in IF/ID
//   hz_state     : FSM state for debug
// Inputs: ID decode fields, ex_branch_taken from EX, stall_back from MEM.
// All outputs are forced to 0 while rst is high.
module riscv_core_hazard
  import riscv_core_pkg::*;
#(
  parameter int REG_AW       = RF_IDX_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_wr,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              stall_back,
  output logic [1:0]        id_fwd_rs1,
  output logic [1:0]        id_fwd_rs2,
  output logic              id_stall,
  output logic              id_bubble,
  output logic              if_flush,
  output logic [1:0]        hz_state
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  hz_state_t          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               bubble_reg, flush_reg;
  logic               stall_comb, bubble_comb, flush_comb;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  shadow_entry_t      shadow_reg [3];
  shadow_entry_t      ex_next;

  logic [REG_AW-1:0]  rs_vec      [2];
  logic               rs_used_vec [2];
  logic               hit         [2][3];
  logic [1:0]         fwd_sel     [2];
  logic               load_use;
  logic               issue;

  assign rs_vec[0]      = id_rs1;
  assign rs_vec[1]      = id_rs2;
  assign rs_used_vec[0] = id_rs1_used;
  assign rs_used_vec[1] = id_rs2_used;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      for (genvar gs = 0; gs < 3; gs++) begin : g_stage
        riscv_core_hazard_match #(.REG_AW(REG_AW)) u_match (
          .entry_valid (shadow_reg[gs].valid),
          .entry_wr    (shadow_reg[gs].wr),
          .entry_rd    (shadow_reg[gs].rd),
          .rs          (rs_vec[gi]),
          .rs_used     (rs_used_vec[gi]),
          .hit         (hit[gi][gs])
        );
      end
    end
  endgenerate

  // A load in EX has no data yet; it is skipped for forwarding and
  // turns into a load-use interlock instead.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fwd_sel[s] = FWD_RF;
      if (hit[s][0] && !shadow_reg[0].load) begin
        fwd_sel[s] = FWD_EX;
      end else if (hit[s][1]) begin
        fwd_sel[s] = FWD_MEM;
      end else if (hit[s][2]) begin
        fwd_sel[s] = FWD_WB;
      end
    end
  end

  assign load_use = id_valid & shadow_reg[0].load & (hit[0][0] | hit[1][0]);

  // Next state and control. stall_back freezes everything and replays the
  // previous bubble/flush values, so EX sees a consistent control word.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stall_comb  = 1'b0;
    bubble_comb = 1'b0;
    flush_comb  = 1'b0;
    if (stall_back) begin
      stall_comb  = 1'b1;
      bubble_comb = bubble_reg;
      flush_comb  = flush_reg;
    end else begin
      case (state_reg)
        RUN: begin
          if (ex_branch_taken) begin
            // The branch cycle itself is the first flush cycle.
            flush_comb  = 1'b1;
            bubble_comb = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            stall_comb  = 1'b1;
            bubble_comb = 1'b1;
            state_next  = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          state_next = RUN;
        end
        FLUSH: begin
          flush_comb  = 1'b1;
          bubble_comb = 1'b1;
          cnt_next    = cnt_reg - CNT_W'(1);
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign issue = id_valid & ~stall_comb & (state_reg != FLUSH) & ~ex_branch_taken;

  always_comb begin
    ex_next = SHADOW_EMPTY;
    if (issue) begin
      ex_next.valid = 1'b1;
      ex_next.rd    = id_rd;
      ex_next.wr    = id_rd_wr;
      ex_next.load  = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      cnt_reg    <= '0;
      bubble_reg <= 1'b0;
      flush_reg  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shadow_reg[i] <= SHADOW_EMPTY;
      end
    end else if (!stall_back) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bubble_reg    <= bubble_comb;
      flush_reg     <= flush_comb;
      shadow_reg[0] <= ex_next;
      shadow_reg[1] <= shadow_reg[0];
      shadow_reg[2] <= shadow_reg[1];
    end
  end

  // Outside RUN, EX only ever holds a bubble, so it cannot resolve a branch.
  always_ff @(posedge clk) begin
    if (!rst && !stall_back && state_reg != RUN) begin
      assert (!ex_branch_taken);
    end
  end

  assign id_fwd_rs1 = rst ? FWD_RF : fwd_sel[0];
  assign id_fwd_rs2 = rst ? FWD_RF : fwd_sel[1];
  assign id_stall   = ~rst & stall_comb;
  assign id_bubble  = ~rst & bubble_comb;
  assign if_flush   = ~rst & flush_comb;
  assign hz_state   = rst ? 2'b00 : state_reg;

endmodule
